// File: rtl/bus_hold_arbiter_if.sv
// Hold request/acknowledge bundle between the arbiter, external masters and the BCU.
interface bus_hold_arbiter_if #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned OWNER_W = 2
);
  logic [NREQ-1:0]    hold_req;
  logic [NREQ-1:0]    hold_ack;
  logic               cpu_hold;
  logic               cpu_idle;
  logic               cpu_n_buslock;
  logic               bus_float;
  logic [OWNER_W-1:0] bus_owner;
  logic               busy;

  // Arbiter side
  modport master (
    input  hold_req, cpu_idle, cpu_n_buslock,
    output hold_ack, cpu_hold, bus_float, bus_owner, busy
  );

  // Requester / BCU side
  modport slave (
    output hold_req, cpu_idle, cpu_n_buslock,
    input  hold_ack, cpu_hold, bus_float, bus_owner, busy
  );
endinterface

// File: rtl/bus_hold_arbiter.sv
// Round-robin bus hold arbiter: parks the BCU at a cycle boundary, grants one
// external master at a time and guarantees the CPU a window between grants.
module bus_hold_arbiter #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned CPU_SLOTS = 4,
  parameter int unsigned OWNER_W   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce_2,
  bus_hold_arbiter_if.master  bus
);

  localparam int unsigned CNT_W = (CPU_SLOTS < 1) ? 1 : $clog2(CPU_SLOTS + 1);
  localparam int unsigned PTR_W = (NREQ < 2) ? 1 : $clog2(NREQ);

  typedef enum logic [1:0] {
    CPU_OWN   = 2'd0,
    HOLD_WAIT = 2'd1,
    GRANTED   = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               float_q, float_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic               busy_q, busy_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]   slot_q, slot_d;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;

  // Round-robin search: first active request at or above rr_q, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!win_found && bus.hold_req[PTR_W'((32'(rr_q) + i) % NREQ)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'((32'(rr_q) + i) % NREQ);
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    ack_d      = ack_q;
    cpu_hold_d = cpu_hold_q;
    float_d    = float_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    slot_d     = slot_q;

    case (state_q)
      CPU_OWN: begin
        if (slot_q != CNT_W'(CPU_SLOTS)) begin
          slot_d = slot_q + CNT_W'(1);
        end
        if ((|bus.hold_req) && (slot_q == CNT_W'(CPU_SLOTS))) begin
          state_d    = HOLD_WAIT;
          cpu_hold_d = 1'b1;
        end
      end
      HOLD_WAIT: begin
        if (!(|bus.hold_req)) begin
          state_d    = CPU_OWN;
          cpu_hold_d = 1'b0;
        end else if (bus.cpu_idle && bus.cpu_n_buslock && win_found) begin
          state_d = GRANTED;
          ack_d   = NREQ'(1) << win_idx;
          float_d = 1'b1;
          owner_d = OWNER_W'(win_idx) + OWNER_W'(1);
          rr_d    = PTR_W'((32'(win_idx) + 32'd1) % NREQ);
        end
      end
      GRANTED: begin
        // No preemption: only the current owner's request matters.
        if ((bus.hold_req & ack_q) == '0) begin
          state_d = RELEASE;
          ack_d   = '0;
        end
      end
      RELEASE: begin
        // One turnaround tick with drivers still floated.
        state_d    = CPU_OWN;
        float_d    = 1'b0;
        cpu_hold_d = 1'b0;
        owner_d    = '0;
        slot_d     = '0;
      end
      default: begin
        state_d = CPU_OWN;
      end
    endcase

    busy_d = (state_d != CPU_OWN);
  end

  // State and registered outputs; synchronous reset beats ce_2.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CPU_OWN;
      ack_q      <= '0;
      cpu_hold_q <= 1'b0;
      float_q    <= 1'b0;
      owner_q    <= '0;
      busy_q     <= 1'b0;
      rr_q       <= '0;
      slot_q     <= CNT_W'(CPU_SLOTS);
    end else if (ce_2) begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      cpu_hold_q <= cpu_hold_d;
      float_q    <= float_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
      rr_q       <= rr_d;
      slot_q     <= slot_d;
    end
  end

  assign bus.hold_ack  = ack_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.bus_float = float_q;
  assign bus.bus_owner = owner_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/bus_hold_arbiter.md
Name: bus_hold_arbiter

Overview:
Shares the external V33 bus between the CPU bus control unit and up to NREQ external bus masters (DMA, video fetch) using a hold request/acknowledge protocol. Asks the BCU to stop starting new cycles, waits for a bus-cycle boundary with the bus unlocked, then grants one requester round-robin. Guarantees the CPU a minimum window between consecutive grants. Sits beside bus_control_unit in the CPU top; drives its hold input and the address/data output-enable.

Parameters:
NREQ, 2, number of external hold requesters (1..4)
CPU_SLOTS, 4, minimum ce_2 ticks the CPU owns the bus after a release before the next grant
OWNER_W, 2, width of bus_owner; must be >= clog2(NREQ+1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high
ce_2  input  1  phase-2 clock enable; all state changes occur only on clk edges with ce_2=1
hold_req  input  NREQ  per-requester hold request, level, held for the whole tenure
hold_ack  output  NREQ  per-requester grant, one-hot or zero, registered
cpu_hold  output  1  to BCU: do not start a new bus cycle
cpu_idle  input  1  BCU in T_IDLE and not starting a cycle this tick
cpu_n_buslock  input  1  BCU buslock, active-low; 0 forbids granting
bus_float  output  1  1 = CPU address/data/status drivers disabled
bus_owner  output  OWNER_W  0 = CPU, k = requester k-1
busy  output  1  1 in any state other than CPU_OWN

Behaviour:
- Reset (synchronous, overrides ce_2): state=CPU_OWN, hold_ack=0, cpu_hold=0, bus_float=0, bus_owner=0, busy=0, rr_ptr=0, slot_cnt=CPU_SLOTS (the first request is not delayed).
- All outputs are registered and change only on ce_2 ticks.
- States: CPU_OWN, HOLD_WAIT, GRANTED, RELEASE.
- CPU_OWN: slot_cnt increments each tick, saturating at CPU_SLOTS. If any hold_req=1 and slot_cnt==CPU_SLOTS: go to HOLD_WAIT and set cpu_hold=1 on the same edge.
- HOLD_WAIT:
  - If all hold_req=0 (withdrawn): return to CPU_OWN, cpu_hold=0, no grant issued, slot_cnt unchanged.
  - Else if cpu_idle=1 and cpu_n_buslock=1: pick winner = first requester with hold_req=1, searching from rr_ptr upward with wrap modulo NREQ. Go to GRANTED; set hold_ack[winner]=1, bus_float=1, bus_owner=winner+1, rr_ptr=(winner+1) mod NREQ.
  - Otherwise stay.
  - Minimum latency from request to ack: 2 ce_2 ticks when the CPU is idle.
- GRANTED: hold the grant until the winner drops hold_req. Requests from other masters are ignored; there is no preemption. When the winner's hold_req=0: go to RELEASE, hold_ack=0, bus_float stays 1.
- RELEASE: exactly one turnaround tick, then CPU_OWN with bus_float=0, cpu_hold=0, bus_owner=0, slot_cnt=0.
  - bus_float is therefore deasserted one tick after hold_ack falls.
  - A pending request from another master waits CPU_SLOTS ticks in CPU_OWN before HOLD_WAIT.
- cpu_hold stays 1 in HOLD_WAIT, GRANTED and RELEASE.
- Locked sequences: cpu_n_buslock=0 blocks the HOLD_WAIT→GRANTED transition only. It never affects a grant already issued.
- Simultaneous events: a request arriving in the same tick another is released is handled only after RELEASE and the CPU_SLOTS window. Multiple requesters rising together resolve by rr_ptr.
- CPU_SLOTS=0: CPU_OWN may move to HOLD_WAIT on the first CPU_OWN tick after RELEASE.
- ce_2=0: all state frozen, including counters.
- Reset mid-tenure: hold_ack drops and the CPU regains the bus on the next edge; no RELEASE tick. The external master must tolerate this.
- Invariant: popcount(hold_ack) <= 1. bus_float=1 whenever any hold_ack=1.

Test Plan:
- hold_req[0] rises with cpu_idle=1, cpu_n_buslock=1 → cpu_hold=1 after 1 tick, hold_ack=01 and bus_owner=1 after 2 ticks; drop req → ack=0 next tick, bus_float=0 and cpu_hold=0 one tick later.
- Request while cpu_idle=0 for 5 ticks → hold_ack stays 0 and cpu_hold=1 for those 5 ticks; grant on the tick after cpu_idle=1.
- cpu_n_buslock=0 for 3 ticks with cpu_idle=1 → no grant; grant the tick after buslock releases.
- hold_req=11 continuously, each master releasing after 3 ticks → grants alternate 0,1,0. Each new grant follows previous RELEASE + 4 CPU_OWN ticks (CPU_SLOTS=4).
- Request withdrawn in HOLD_WAIT before cpu_idle → state returns to CPU_OWN, hold_ack never asserted, cpu_hold=0.
- Reset asserted while GRANTED → next edge hold_ack=0, bus_float=0, bus_owner=0, busy=0. Toggling ce_2=0 mid-HOLD_WAIT freezes all outputs.
